// File: rtl/reg_bank_pc.sv
// Register bank with one write port, a register-to-register MOV, two registered read ports
// and a program counter in the last slot. Define REG_BANK_BYPASS_EN to forward same-edge updates.
module reg_bank_pc #(
    parameter int unsigned RegisterSize      = 32,
    parameter int unsigned AmountOfRegisters = 16,
    parameter int unsigned PcStep            = 4,
    parameter logic [RegisterSize-1:0] ResetPc = '0,
    parameter int unsigned AddrWidth         = $clog2(AmountOfRegisters)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    writeEnable,
    input  logic [AddrWidth-1:0]    writeRegister,
    input  logic [RegisterSize-1:0] writeValue,
    input  logic                    movEnable,
    input  logic [AddrWidth-1:0]    movOrigin,
    input  logic [AddrWidth-1:0]    movDestiny,
    input  logic [AddrWidth-1:0]    readRegisterA,
    input  logic [AddrWidth-1:0]    readRegisterB,
    output logic [RegisterSize-1:0] readValueA,
    output logic [RegisterSize-1:0] readValueB,
    input  logic                    pcAdvance,
    input  logic                    pcLoad,
    input  logic [RegisterSize-1:0] pcLoadValue,
    output logic [RegisterSize-1:0] pc
);

    localparam logic [AddrWidth-1:0] PcIndex = AddrWidth'(AmountOfRegisters - 1);

    logic [RegisterSize-1:0] regs_q [AmountOfRegisters];
    logic [RegisterSize-1:0] regs_d [AmountOfRegisters];
    logic [RegisterSize-1:0] read_a_q, read_b_q;
    logic [RegisterSize-1:0] mov_value;

    assign mov_value = regs_q[movOrigin];

    always_comb begin
        regs_d = regs_q;
        // General registers: write port beats MOV on a shared destination.
        for (int i = 0; i < int'(AmountOfRegisters) - 1; i++) begin
            if (writeEnable && writeRegister == AddrWidth'(i)) begin
                regs_d[i] = writeValue;
            end else if (movEnable && movDestiny == AddrWidth'(i)) begin
                regs_d[i] = mov_value;
            end
        end
        if (pcLoad) begin
            regs_d[PcIndex] = pcLoadValue;
        end else if (writeEnable && writeRegister == PcIndex) begin
            regs_d[PcIndex] = writeValue;
        end else if (movEnable && movDestiny == PcIndex) begin
            regs_d[PcIndex] = mov_value;
        end else if (pcAdvance) begin
            regs_d[PcIndex] = regs_q[PcIndex] + RegisterSize'(PcStep);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(AmountOfRegisters) - 1; i++) begin
                regs_q[i] <= '0;
            end
            regs_q[PcIndex] <= ResetPc;
            read_a_q        <= '0;
            read_b_q        <= '0;
        end else begin
            regs_q <= regs_d;
`ifdef REG_BANK_BYPASS_EN
            read_a_q <= regs_d[readRegisterA];
            read_b_q <= regs_d[readRegisterB];
`else
            read_a_q <= regs_q[readRegisterA];
            read_b_q <= regs_q[readRegisterB];
`endif
        end
    end

    assign readValueA = read_a_q;
    assign readValueB = read_b_q;
    assign pc         = regs_q[PcIndex];

endmodule

// File: tb/tb_reg_bank_pc.sv
// Self-checking bench for reg_bank_pc: directed scenarios followed by random traffic,
// all checked against an array-based reference model of the register file.
module tb_reg_bank_pc;

    localparam int unsigned W  = 32;
    localparam int unsigned N  = 16;
    localparam int unsigned AW = 4;
    localparam int unsigned PC = N - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          writeEnable;
    logic [AW-1:0] writeRegister;
    logic [W-1:0]  writeValue;
    logic          movEnable;
    logic [AW-1:0] movOrigin, movDestiny;
    logic [AW-1:0] readRegisterA, readRegisterB;
    logic [W-1:0]  readValueA, readValueB;
    logic          pcAdvance, pcLoad;
    logic [W-1:0]  pcLoadValue;
    logic [W-1:0]  pc;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state
    logic [W-1:0] m_regs [N];
    logic [W-1:0] m_ra, m_rb;

    reg_bank_pc dut (
        .clk          (clk),
        .reset        (reset),
        .writeEnable  (writeEnable),
        .writeRegister(writeRegister),
        .writeValue   (writeValue),
        .movEnable    (movEnable),
        .movOrigin    (movOrigin),
        .movDestiny   (movDestiny),
        .readRegisterA(readRegisterA),
        .readRegisterB(readRegisterB),
        .readValueA   (readValueA),
        .readValueB   (readValueB),
        .pcAdvance    (pcAdvance),
        .pcLoad       (pcLoad),
        .pcLoadValue  (pcLoadValue),
        .pc           (pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        reset = 1'b0; writeEnable = 1'b0; writeRegister = '0; writeValue = '0;
        movEnable = 1'b0; movOrigin = '0; movDestiny = '0;
        readRegisterA = '0; readRegisterB = '0;
        pcAdvance = 1'b0; pcLoad = 1'b0; pcLoadValue = '0;
    endtask

    // Apply current inputs for one edge: predict, clock, then compare outputs.
    task automatic tick(input string tag);
        logic [W-1:0] nxt [N];
        nxt = m_regs;
        if (reset) begin
            foreach (nxt[i]) nxt[i] = '0;
            nxt[PC] = '0;
            m_ra = '0;
            m_rb = '0;
        end else begin
            // Lowest priority first; later assignments override.
            if (pcAdvance) nxt[PC] = m_regs[PC] + W'(4);
            if (movEnable) nxt[movDestiny] = m_regs[movOrigin];
            if (writeEnable) nxt[writeRegister] = writeValue;
            if (pcLoad) nxt[PC] = pcLoadValue;
`ifdef REG_BANK_BYPASS_EN
            m_ra = nxt[readRegisterA];
            m_rb = nxt[readRegisterB];
`else
            m_ra = m_regs[readRegisterA];
            m_rb = m_regs[readRegisterB];
`endif
        end
        m_regs = nxt;
        @(posedge clk);
        #1;
        check({tag, ".rdA"}, readValueA, m_ra);
        check({tag, ".rdB"}, readValueB, m_rb);
        check({tag, ".pc"}, pc, m_regs[PC]);
    endtask

    initial begin
        foreach (m_regs[i]) m_regs[i] = 'x;
        m_ra = 'x;
        m_rb = 'x;
        idle();
        @(negedge clk);

        // Reset, then read r3 and PC
        reset = 1'b1;
        tick("reset");
        idle();
        readRegisterA = 4'd3; readRegisterB = 4'(PC);
        tick("rd_after_reset");
        check("r3_zero", readValueA, 32'h0);
        check("pc_reset_read", readValueB, 32'h0);
        check("pc_reset", pc, 32'h0);

        // Write r5, MOV r5->r7, read r7 and r5
        idle(); writeEnable = 1'b1; writeRegister = 4'd5; writeValue = 32'hA5A5A5A5;
        tick("wr_r5");
        idle(); movEnable = 1'b1; movOrigin = 4'd5; movDestiny = 4'd7;
        tick("mov_5_7");
        idle(); readRegisterA = 4'd7; readRegisterB = 4'd5;
        tick("rd_r7_r5");
        check("r7_after_mov", readValueA, 32'hA5A5A5A5);
        check("r5_unchanged", readValueB, 32'hA5A5A5A5);

        // Write and MOV to the same register: write wins
        idle(); writeEnable = 1'b1; writeRegister = 4'd9; writeValue = 32'h22;
        tick("wr_r9");
        idle(); writeEnable = 1'b1; writeRegister = 4'd2; writeValue = 32'h11;
        movEnable = 1'b1; movOrigin = 4'd9; movDestiny = 4'd2;
        tick("wr_mov_r2");
        idle(); readRegisterA = 4'd2; readRegisterB = 4'd9;
        tick("rd_r2");
        check("r2_write_wins", readValueA, 32'h11);

        // PC wrap and load priority
        idle(); pcLoad = 1'b1; pcLoadValue = 32'hFFFFFFFC;
        tick("pc_load_top");
        check("pc_top", pc, 32'hFFFFFFFC);
        idle(); pcAdvance = 1'b1;
        tick("pc_wrap");
        check("pc_wrapped", pc, 32'h0);
        idle(); pcLoad = 1'b1; pcLoadValue = 32'h100; pcAdvance = 1'b1;
        writeEnable = 1'b1; writeRegister = 4'(PC); writeValue = 32'h200;
        tick("pc_prio");
        check("pc_load_wins", pc, 32'h100);

        // Read-during-write on r4
        idle(); writeEnable = 1'b1; writeRegister = 4'd4; writeValue = 32'h77;
        tick("wr_r4_old");
        idle(); writeEnable = 1'b1; writeRegister = 4'd4; writeValue = 32'h33;
        readRegisterA = 4'd4;
        tick("rdw_r4");
`ifdef REG_BANK_BYPASS_EN
        check("r4_rdw", readValueA, 32'h33);
`else
        check("r4_rdw", readValueA, 32'h77);
`endif

        // Reset during concurrent activity
        idle(); reset = 1'b1; writeEnable = 1'b1; writeRegister = 4'd6; writeValue = 32'hDEAD;
        movEnable = 1'b1; movOrigin = 4'd5; movDestiny = 4'd8; pcAdvance = 1'b1;
        readRegisterA = 4'd5; readRegisterB = 4'd9;
        tick("reset_busy");
        check("reset_rdA", readValueA, 32'h0);
        check("reset_rdB", readValueB, 32'h0);
        check("reset_pc", pc, 32'h0);
        for (int i = 0; i < int'(N); i += 2) begin
            idle(); readRegisterA = 4'(i); readRegisterB = 4'(i + 1);
            tick("rd_sweep");
        end

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            idle();
            reset         = ($urandom_range(0, 39) == 0);
            writeEnable   = $urandom_range(0, 1) == 1;
            writeRegister = 4'($urandom_range(0, N - 1));
            writeValue    = $urandom;
            movEnable     = $urandom_range(0, 2) == 0;
            movOrigin     = 4'($urandom_range(0, N - 1));
            movDestiny    = 4'($urandom_range(0, N - 1));
            readRegisterA = 4'($urandom_range(0, N - 1));
            readRegisterB = 4'($urandom_range(0, N - 1));
            pcAdvance     = $urandom_range(0, 1) == 1;
            pcLoad        = $urandom_range(0, 7) == 0;
            pcLoadValue   = $urandom;
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
